// File: rtl/ecc_ctrl_pkg.sv
// Shared types for the ECC operation sequencer: FSM states, mode/width/status
// encodings and a legality helper for the start request.
package ecc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENC_REQ  = 3'd1,
    S_ENC_WAIT = 3'd2,
    S_NOISE    = 3'd3,
    S_DEC_REQ  = 3'd4,
    S_DEC_WAIT = 3'd5,
    S_DONE     = 3'd6
  } ecc_state_e;

  typedef enum logic [1:0] {
    MODE_ENC  = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_FULL = 2'b10,
    MODE_ILL  = 2'b11
  } ecc_mode_e;

  typedef enum logic [1:0] {
    WID_8   = 2'b00,
    WID_16  = 2'b01,
    WID_32  = 2'b10,
    WID_ILL = 2'b11
  } ecc_width_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_ILLEGAL = 2'b01,
    STAT_TIMEOUT = 2'b10,
    STAT_RSVD    = 2'b11
  } ecc_status_e;

  function automatic logic op_legal(input logic [1:0] mode, input logic [1:0] width);
    return (mode != MODE_ILL) && (width != WID_ILL);
  endfunction

endpackage

// File: rtl/ecc_op_sequencer_if.sv
// Request/response bundle between the controlling agent (master) and the
// ECC operation sequencer (slave), plus the sequencer's state for observation.
interface ecc_op_sequencer_if;
  import ecc_ctrl_pkg::*;

  // start is a single-cycle request, accepted only while the sequencer is idle;
  // enc_done/dec_done are single-cycle acknowledgements that only count while
  // the matching WAIT state is active. go/noise/op_done are single-cycle strobes.
  logic       start;
  logic [1:0] ctrl_mode;
  logic [1:0] cw_width;
  logic       enc_done;
  logic       dec_done;

  logic [1:0] mode_q;
  logic [1:0] width_q;
  logic       enc_go;
  logic       noise_en;
  logic       dec_go;
  logic       busy;
  logic       op_done;
  logic [1:0] status;
  logic       start_ovr;
  ecc_state_e state_dbg;

  modport master (
    output start, ctrl_mode, cw_width, enc_done, dec_done,
    input  mode_q, width_q, enc_go, noise_en, dec_go, busy, op_done,
           status, start_ovr, state_dbg
  );

  modport slave (
    input  start, ctrl_mode, cw_width, enc_done, dec_done,
    output mode_q, width_q, enc_go, noise_en, dec_go, busy, op_done,
           status, start_ovr, state_dbg
  );

endinterface

// File: rtl/ecc_timeout_counter.sv
// Saturating wait counter; expired flags the last allowed wait cycle.
module ecc_timeout_counter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/ecc_op_sequencer.sv
// Sequences one ECC operation: encode, decode or encode->noise->decode,
// with per-stage timeout and a registered completion status.
module ecc_op_sequencer
  import ecc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  ecc_op_sequencer_if.slave   bus
);

  ecc_state_e state_q, state_d;
  logic [1:0] lat_mode_q, lat_mode_d;
  logic [1:0] lat_width_q, lat_width_d;
  logic [1:0] status_q, status_d;
  logic       start_ovr_q, start_ovr_d;

  logic in_wait, wait_done, cnt_clr, cnt_en, expired;

  // Counter sits at zero outside WAIT states, so every WAIT entry starts fresh.
  assign in_wait   = (state_q == S_ENC_WAIT) || (state_q == S_DEC_WAIT);
  assign wait_done = ((state_q == S_ENC_WAIT) && bus.enc_done) ||
                     ((state_q == S_DEC_WAIT) && bus.dec_done);
  assign cnt_clr   = !in_wait;
  assign cnt_en    = in_wait && !wait_done;

  ecc_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_mode_q  <= '0;
      lat_width_q <= '0;
      status_q    <= '0;
      start_ovr_q <= 1'b0;
    end else begin
      lat_mode_q  <= lat_mode_d;
      lat_width_q <= lat_width_d;
      status_q    <= status_d;
      start_ovr_q <= start_ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_mode_d  = lat_mode_q;
    lat_width_d = lat_width_q;
    status_d    = status_q;
    start_ovr_d = start_ovr_q;

    if (bus.start && (state_q != S_IDLE)) begin
      start_ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          lat_mode_d  = bus.ctrl_mode;
          lat_width_d = bus.cw_width;
          status_d    = STAT_OK;
          start_ovr_d = 1'b0;
          if (!op_legal(bus.ctrl_mode, bus.cw_width)) begin
            state_d  = S_DONE;
            status_d = STAT_ILLEGAL;
          end else if (bus.ctrl_mode == MODE_DEC) begin
            state_d = S_DEC_REQ;
          end else begin
            state_d = S_ENC_REQ;
          end
        end
      end
      S_ENC_REQ: state_d = S_ENC_WAIT;
      S_ENC_WAIT: begin
        // A done arriving on the expiry cycle still completes normally.
        if (bus.enc_done) begin
          state_d = (lat_mode_q == MODE_FULL) ? S_NOISE : S_DONE;
        end else if (expired) begin
          state_d  = S_DONE;
          status_d = STAT_TIMEOUT;
        end
      end
      S_NOISE:   state_d = S_DEC_REQ;
      S_DEC_REQ: state_d = S_DEC_WAIT;
      S_DEC_WAIT: begin
        if (bus.dec_done) begin
          state_d = S_DONE;
        end else if (expired) begin
          state_d  = S_DONE;
          status_d = STAT_TIMEOUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.enc_go    = (state_q == S_ENC_REQ);
    bus.noise_en  = (state_q == S_NOISE);
    bus.dec_go    = (state_q == S_DEC_REQ);
    bus.op_done   = (state_q == S_DONE);
    bus.busy      = (state_q != S_IDLE);
    bus.mode_q    = lat_mode_q;
    bus.width_q   = lat_width_q;
    bus.status    = status_q;
    bus.start_ovr = start_ovr_q;
    bus.state_dbg = state_q;
  end

endmodule
